// File: rtl/wb_sram_ctrl.sv
// wb_sram_ctrl: Wishbone B3 slave fronting a single-port synchronous SRAM
// macro with per-byte write enables.
// Build option WB_SRAM_BURST_EN: when defined, constant-address and
// incrementing (linear, wrap4/8/16) bursts run at one beat per cycle.
// When undefined, cti/bte are ignored and every access is classic.
module wb_sram_ctrl #(
  parameter int unsigned DW        = 32,
  parameter int unsigned MEM_WORDS = 32768,
  parameter int unsigned AW        = 32,
  parameter int unsigned MAW       = $clog2(MEM_WORDS)
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n_i,
  input  logic [AW-1:0]     wb_adr_i,
  input  logic [DW-1:0]     wb_dat_i,
  input  logic [DW/8-1:0]   wb_sel_i,
  input  logic              wb_we_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic [2:0]        wb_cti_i,
  input  logic [1:0]        wb_bte_i,
  output logic [DW-1:0]     wb_dat_o,
  output logic              wb_ack_o,
  output logic              wb_err_o,
  output logic              wb_rty_o,
  output logic              sram_cen_n_o,
  output logic              sram_wen_n_o,
  output logic [DW/8-1:0]   sram_bwen_n_o,
  output logic [MAW-1:0]    sram_adr_o,
  output logic [DW-1:0]     sram_d_o,
  input  logic [DW-1:0]     sram_q_i
);

  localparam int unsigned SW = DW / 8;
  localparam int unsigned LB = $clog2(SW);
  localparam int unsigned HI = MAW + LB;

  typedef enum logic [1:0] {
    IDLE,
    SGL,
    ERRS
`ifdef WB_SRAM_BURST_EN
    , BRST
`endif
  } state_t;

  state_t          state, state_d;
  logic [MAW-1:0]  adr_r, adr_d;
  logic [MAW-1:0]  wadr;
  logic            req, rerr;
  logic            ack, err, cen_n, wen_n;
  logic [SW-1:0]   bwen_n;
  logic [MAW-1:0]  sram_adr;
  // Inputs that are deliberately ignored (byte offset, and burst controls
  // when bursts are compiled out).
  logic            unused_bits;

`ifdef WB_SRAM_BURST_EN
  logic [1:0]      bte_r, bte_d;
  logic [2:0]      cti_r, cti_d;
  logic [MAW-1:0]  adr_nxt;

  // Next burst word: constant holds, linear wraps at the memory size,
  // wrap-N only advances the low log2(N) bits.
  function automatic logic [MAW-1:0] nxt(input logic [MAW-1:0] a,
                                         input logic [2:0]     cti,
                                         input logic [1:0]     bte);
    logic [MAW-1:0] inc;
    logic [MAW-1:0] mask;
    inc = a + MAW'(1);
    case (bte)
      2'b01:   mask = MAW'(3);
      2'b10:   mask = MAW'(7);
      2'b11:   mask = MAW'(15);
      default: mask = '1;
    endcase
    if (cti == 3'b001) nxt = a;
    else               nxt = (inc & mask) | (a & ~mask);
  endfunction

  assign adr_nxt     = nxt(adr_r, cti_r, bte_r);
  assign unused_bits = ^wb_adr_i[LB-1:0];
`else
  assign unused_bits = ^{wb_adr_i[LB-1:0], wb_cti_i, wb_bte_i};
`endif

  assign wadr = wb_adr_i[HI-1:LB];
  assign req  = wb_cyc_i & wb_stb_i;
  assign rerr = req & (|(wb_adr_i >> HI));

  // State, burst address and latched burst type.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state <= IDLE;
      adr_r <= '0;
`ifdef WB_SRAM_BURST_EN
      bte_r <= '0;
      cti_r <= '0;
`endif
    end else begin
      state <= state_d;
      adr_r <= adr_d;
`ifdef WB_SRAM_BURST_EN
      bte_r <= bte_d;
      cti_r <= cti_d;
`endif
    end
  end

  // Next state, bus terminations and SRAM strobes.
  always_comb begin
    state_d  = state;
    adr_d    = adr_r;
    ack      = 1'b0;
    err      = 1'b0;
    cen_n    = 1'b1;
    wen_n    = 1'b1;
    bwen_n   = '1;
    sram_adr = adr_r;
`ifdef WB_SRAM_BURST_EN
    bte_d    = bte_r;
    cti_d    = cti_r;
`endif
    case (state)
      IDLE: begin
        if (req) begin
          if (rerr) begin
            state_d = ERRS;
          end else begin
            adr_d   = wadr;
            state_d = SGL;
            // Prefetch the first read word so data is ready in the ack cycle.
            if (!wb_we_i) begin
              cen_n    = 1'b0;
              sram_adr = wadr;
            end
`ifdef WB_SRAM_BURST_EN
            if (wb_cti_i == 3'b001 || wb_cti_i == 3'b010) begin
              state_d = BRST;
              bte_d   = wb_bte_i;
              cti_d   = wb_cti_i;
            end
`endif
          end
        end
      end
      SGL: begin
        state_d = IDLE;
        if (req) begin
          ack = 1'b1;
          if (wb_we_i) begin
            cen_n  = 1'b0;
            wen_n  = 1'b0;
            bwen_n = ~wb_sel_i;
          end
        end
      end
      ERRS: begin
        state_d = IDLE;
        err     = req;
      end
`ifdef WB_SRAM_BURST_EN
      BRST: begin
        if (!wb_cyc_i) begin
          state_d = IDLE;
        end else if (wb_stb_i) begin
          if (wadr != adr_r) begin
            err     = 1'b1;
            state_d = IDLE;
          end else begin
            ack   = 1'b1;
            cen_n = 1'b0;
            adr_d = adr_nxt;
            if (wb_we_i) begin
              wen_n  = 1'b0;
              bwen_n = ~wb_sel_i;
            end else begin
              // Read ahead: the word for the next beat lands on this edge.
              sram_adr = adr_nxt;
            end
            if (wb_cti_i == 3'b111) state_d = IDLE;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    if (!wb_cyc_i) state_d = IDLE;
  end

  assign wb_dat_o      = sram_q_i;
  assign wb_ack_o      = ack;
  assign wb_err_o      = err;
  assign wb_rty_o      = 1'b0;
  // The prefetch strobe depends on bus inputs, so reset gates it directly.
  assign sram_cen_n_o  = cen_n | ~wb_rst_n_i;
  assign sram_wen_n_o  = wen_n;
  assign sram_bwen_n_o = bwen_n;
  assign sram_adr_o    = sram_adr;
  assign sram_d_o      = wb_dat_i;

endmodule

// File: tb/tb_wb_sram_ctrl.sv
// tb_wb_sram_ctrl: randomized bench for wb_sram_ctrl with a behavioural SRAM
// macro and a word-array reference memory. Burst scenarios are compiled in
// only when WB_SRAM_BURST_EN is defined.
`timescale 1ns/1ps
module tb_wb_sram_ctrl;

  localparam int unsigned DW        = 32;
  localparam int unsigned MEM_WORDS = 32768;
  localparam int unsigned AW        = 32;
  localparam int unsigned MAW       = 15;
  localparam int unsigned SW        = DW / 8;
  localparam int unsigned LBW       = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [AW-1:0]   adr;
  logic [DW-1:0]   dat_w;
  logic [SW-1:0]   sel;
  logic            we, cyc, stb;
  logic [2:0]      cti;
  logic [1:0]      bte;
  logic [DW-1:0]   dat_r;
  logic            ack, err, rty;
  logic            cen_n, wen_n;
  logic [SW-1:0]   bwen;
  logic [MAW-1:0]  sram_adr;
  logic [DW-1:0]   sram_d;
  logic [DW-1:0]   sram_q;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] sram_mem [MEM_WORDS];
  logic [DW-1:0] ref_mem  [MEM_WORDS];

  always #5 clk = ~clk;

  wb_sram_ctrl #(.DW(DW), .MEM_WORDS(MEM_WORDS), .AW(AW)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wb_adr_i(adr), .wb_dat_i(dat_w),
    .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb),
    .wb_cti_i(cti), .wb_bte_i(bte), .wb_dat_o(dat_r), .wb_ack_o(ack),
    .wb_err_o(err), .wb_rty_o(rty), .sram_cen_n_o(cen_n),
    .sram_wen_n_o(wen_n), .sram_bwen_n_o(bwen), .sram_adr_o(sram_adr),
    .sram_d_o(sram_d), .sram_q_i(sram_q)
  );

  // Synchronous SRAM macro: byte-masked write, registered read that holds.
  always @(posedge clk) begin
    if (!cen_n) begin
      if (!wen_n) begin
        for (int b = 0; b < int'(SW); b++)
          if (!bwen[b]) sram_mem[sram_adr][8*b +: 8] <= sram_d[8*b +: 8];
      end else begin
        sram_q <= sram_mem[sram_adr];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit c, input bit s, input bit w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [SW-1:0] se,
                       input logic [2:0] ct, input logic [1:0] bt);
    cyc = c; stb = s; we = w; adr = a; dat_w = d; sel = se; cti = ct; bte = bt;
  endtask

  function automatic void ref_write(input logic [MAW-1:0] w, input logic [DW-1:0] d,
                                    input logic [SW-1:0] s);
    for (int b = 0; b < int'(SW); b++)
      if (s[b]) ref_mem[w][8*b +: 8] = d[8*b +: 8];
  endfunction

  // Byte address of a word with a random (ignored) byte offset.
  function automatic logic [AW-1:0] word_adr(input logic [MAW-1:0] w);
    return (AW'(w) << LBW) | AW'($urandom_range(0, SW - 1));
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 3'b000, 2'b00);
      tick();
    end
  endtask

  // Classic single access: request in cycle 0, termination in cycle 1.
  task automatic classic(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [SW-1:0] s, input logic [2:0] ct);
    bit             bad;
    logic [MAW-1:0] wd;
    logic [SW-1:0]  ns;
    bad = (a >> (MAW + LBW)) != 0;
    wd  = a[MAW+LBW-1:LBW];
    ns  = ~s;
    drive(1'b1, 1'b1, w, a, d, s, ct, 2'($urandom_range(0, 3)));
    #1;
    check("c0_ack", ack, 0);
    check("c0_err", err, 0);
    check("c0_cen", cen_n, (!w && !bad) ? 1'b0 : 1'b1);
    if (!w && !bad) check("c0_radr", sram_adr, wd);
    tick();
    check("c1_ack", ack, !bad);
    check("c1_err", err, bad);
    if (bad) begin
      check("c1_cen", cen_n, 1);
    end else if (w) begin
      check("c1_cen", cen_n, 0);
      check("c1_wen", wen_n, 0);
      check("c1_bwen", bwen, ns);
      check("c1_wadr", sram_adr, wd);
      check("c1_wdat", sram_d, d);
      ref_write(wd, d, s);
    end else begin
      check("c1_wen", wen_n, 1);
      check("c1_rdat", dat_r, ref_mem[wd]);
    end
    tick();
  endtask

`ifdef WB_SRAM_BURST_EN
  // Word address of beat i computed straight from the burst rules.
  function automatic logic [MAW-1:0] burst_word(input int start, input logic [2:0] ct,
                                                input logic [1:0] bt, input int i);
    int n, base;
    if (ct == 3'b001) return MAW'(start);
    if (bt == 2'b00) return MAW'((start + i) % MEM_WORDS);
    n    = 2 << bt;
    base = start - (start % n);
    return MAW'(base + ((start % n) + i) % n);
  endfunction

  task automatic burst(input bit w, input int start, input logic [2:0] ct,
                       input logic [1:0] bt, input int n, input int stall_from,
                       input int stall_len, input int bad_beat);
    logic [MAW-1:0] seq [$];
    logic [DW-1:0]  wd [$];
    logic [SW-1:0]  ws [$];
    logic [MAW-1:0] a;
    logic [SW-1:0]  ns;
    int             beat;
    bit             stall, done;
    for (int i = 0; i <= n; i++) begin
      seq.push_back(burst_word(start, ct, bt, i));
      wd.push_back($urandom);
      ws.push_back(w ? SW'($urandom_range(1, 15)) : '1);
    end
    beat = 0;
    done = 1'b0;
    drive(1'b1, 1'b1, w, word_adr(seq[0]), wd[0], ws[0], ct, bt);
    #1;
    check("b0_ack", ack, 0);
    check("b0_err", err, 0);
    check("b0_cen", cen_n, w);
    if (!w) check("b0_radr", sram_adr, seq[0]);
    tick();
    for (int c = 1; !done && c < 4 * n + 8; c++) begin
      stall = (c >= stall_from) && (c < stall_from + stall_len);
      a = (beat == bad_beat) ? (seq[beat] ^ MAW'(1)) : seq[beat];
      drive(1'b1, !stall, w, word_adr(a), wd[beat], ws[beat],
            (beat == n - 1) ? 3'b111 : ct, bt);
      #1;
      if (stall) begin
        check("bs_ack", ack, 0);
        check("bs_err", err, 0);
        check("bs_cen", cen_n, 1);
      end else if (beat == bad_beat) begin
        check("bx_err", err, 1);
        check("bx_ack", ack, 0);
        check("bx_cen", cen_n, 1);
        done = 1'b1;
      end else begin
        check("b_ack", ack, 1);
        check("b_err", err, 0);
        check("b_cen", cen_n, 0);
        if (w) begin
          ns = ~ws[beat];
          check("b_wen", wen_n, 0);
          check("b_bwen", bwen, ns);
          check("b_wadr", sram_adr, seq[beat]);
          ref_write(seq[beat], wd[beat], ws[beat]);
        end else begin
          check("b_rdat", dat_r, ref_mem[seq[beat]]);
          check("b_radr", sram_adr, seq[beat + 1]);
        end
        beat++;
        done = (beat == n);
      end
      tick();
    end
    // After an error the caller continues on the same cycle to prove IDLE.
    if (bad_beat < 0) begin
      drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 3'b000, 2'b00);
      #1;
      check("be_ack", ack, 0);
      check("be_cen", cen_n, 1);
      tick();
    end
  endtask
`endif

  function automatic logic [2:0] rand_cti();
`ifdef WB_SRAM_BURST_EN
    return ($urandom_range(0, 1) != 0) ? 3'b111 : 3'b000;
`else
    return 3'($urandom_range(0, 7));
`endif
  endfunction

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] a;
    for (int i = 0; i < int'(MEM_WORDS); i++) begin
      sram_mem[i] = '0;
      ref_mem[i]  = '0;
    end
    sram_q = '0;

    // Reset with a read request pending: strobes must stay inactive.
    drive(1'b1, 1'b1, 1'b0, '0, '0, '1, 3'b010, 2'b00);
    #2;
    check("rst_ack", ack, 0);
    check("rst_err", err, 0);
    check("rst_rty", rty, 0);
    check("rst_cen", cen_n, 1);
    check("rst_wen", wen_n, 1);
    check("rst_bwen", bwen, 4'hF);
    repeat (2) @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 3'b000, 2'b00);
    #1;
    check("rst_adr", sram_adr, 0);
    #1 rst_n = 1'b1;
    tick();

    // Byte-masked write over a known word.
    classic(1'b1, 32'h100, 32'h1122_3344, 4'hF, 3'b000);
    classic(1'b1, 32'h100, 32'hA5A5_5A5A, 4'b0011, 3'b000);
    classic(1'b0, 32'h100, '0, 4'hF, 3'b000);

    // Preload words 0..7 with their index, back to back.
    for (int i = 0; i < 8; i++)
      classic(1'b1, word_adr(MAW'(i)), DW'(i), 4'hF, 3'b000);

    // Out-of-range read.
    classic(1'b0, 32'h0002_0000, '0, 4'hF, 3'b000);
    classic(1'b0, word_adr(MAW'(5)), '0, 4'hF, 3'b000);

    // Reset in the ack cycle of a write: nothing is committed.
    drive(1'b1, 1'b1, 1'b1, word_adr(MAW'(3)), 32'hDEAD_BEEF, 4'hF, 3'b000, 2'b00);
    tick();
    rst_n = 1'b0;
    #1;
    check("rm_ack", ack, 0);
    check("rm_cen", cen_n, 1);
    check("rm_wen", wen_n, 1);
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 3'b000, 2'b00);
    #1 rst_n = 1'b1;
    tick();
    classic(1'b0, word_adr(MAW'(3)), '0, 4'hF, 3'b000);

`ifdef WB_SRAM_BURST_EN
    burst(1'b0, 0, 3'b010, 2'b00, 8, 100, 0, -1);
    burst(1'b0, 6, 3'b010, 2'b01, 4, 100, 0, -1);
    burst(1'b0, 0, 3'b010, 2'b00, 6, 3, 2, -1);
    burst(1'b1, 16, 3'b010, 2'b10, 8, 100, 0, -1);
    burst(1'b0, 16, 3'b010, 2'b10, 8, 2, 1, -1);
    burst(1'b0, 0, 3'b010, 2'b00, 6, 100, 0, 3);
    classic(1'b0, word_adr(MAW'(2)), '0, 4'hF, 3'b000);
    burst(1'b1, 20, 3'b010, 2'b00, 4, 100, 0, 3);
    classic(1'b0, word_adr(MAW'(20)), '0, 4'hF, 3'b000);
    burst(1'b1, MEM_WORDS - 2, 3'b010, 2'b00, 4, 100, 0, -1);
    burst(1'b0, MEM_WORDS - 2, 3'b010, 2'b00, 4, 100, 0, -1);
    for (int i = 0; i < 30; i++) begin
      int n;
      n = $urandom_range(2, 10);
      burst($urandom_range(0, 1) != 0, $urandom_range(0, 40),
            ($urandom_range(0, 3) == 0) ? 3'b001 : 3'b010,
            2'($urandom_range(0, 3)), n, $urandom_range(1, n),
            $urandom_range(0, 2),
            ($urandom_range(0, 5) == 0) ? $urandom_range(1, n - 1) : -1);
    end
`endif

    // Random classic traffic over a small window with occasional range errors.
    for (int i = 0; i < 150; i++) begin
      a = word_adr(MAW'($urandom_range(0, 31)));
      if ($urandom_range(0, 7) == 0) a = a | (AW'(1) << $urandom_range(MAW + LBW, AW - 1));
      classic($urandom_range(0, 1) != 0, a, $urandom, SW'($urandom_range(1, 15)), rand_cti());
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
